sap1_datapath: RTL

//   Receiving end of the SAP-1 control word. Consumes {CP,EP,Lm_n,CE_n,LI_n,EI_n,LA_n,EA,Alu_Controller,
//   LB_n,LO_n,HLT_E,j} from the controller-sequencer and holds all architectural state: PC, MAR, 16x8 RAM,
//   IR, A, B and OUT. Implements the 8-bit W-bus and the ALU, and returns ins_in = IR[7:4] to the controller.

---
 rtl/sap1_pkg.sv | 33 +++
 rtl/sap1_alu.sv | 27 ++
 rtl/sap1_datapath.sv | 101 ++++++++++
 3 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 widths, ALU operation codes, instruction opcodes and a small helper.
package sap1_pkg;

  localparam int SAP_DW = 8;
  localparam int SAP_AW = 4;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_MUL  = 3'b011;
  localparam logic [2:0] ALU_DIV  = 3'b100;
  localparam logic [2:0] ALU_AND  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_XOR  = 3'b111;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_LDA = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // True when two or more of the four bus-source enables are active at once.
  function automatic logic multi_hot4(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/sap1_alu.sv
// Combinational SAP-1 ALU; results are truncated to DW, divide by zero yields all ones.
module sap1_alu
  import sap1_pkg::*;
#(
  parameter int DW = SAP_DW
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_MUL: y = a * b;
      ALU_DIV: y = (b == '0) ? '1 : a / b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, RAM, IR, A, B, OUT, W-bus mux and ALU driven by the control word.
// Optional BUS_CONTENTION_CHK_EN adds a sticky bus_err output flagging multiple bus drivers.
module sap1_datapath
  import sap1_pkg::*;
#(
  parameter int DW = SAP_DW,
  parameter int AW = SAP_AW
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          CP,
  input  logic          EP,
  input  logic          Lm_n,
  input  logic          CE_n,
  input  logic          LI_n,
  input  logic          EI_n,
  input  logic          LA_n,
  input  logic          EA,
  input  logic [2:0]    Alu_Controller,
  input  logic          LB_n,
  input  logic          LO_n,
  input  logic          HLT_E,
  input  logic          j,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [3:0]    ins_in,
  output logic [DW-1:0] out_port,
  output logic          halted,
  output logic [DW-1:0] wbus
`ifdef BUS_CONTENTION_CHK_EN
  ,
  output logic          bus_err
`endif
);

  logic [AW-1:0] pc;
  logic [AW-1:0] mar;
  logic [DW-1:0] ir;
  logic [DW-1:0] a_reg;
  logic [DW-1:0] b_reg;
  logic [DW-1:0] out_reg;
  logic [DW-1:0] alu_y;
  logic [DW-1:0] ram [2**AW];

  sap1_alu #(.DW(DW)) u_alu (
    .op (Alu_Controller),
    .a  (a_reg),
    .b  (b_reg),
    .y  (alu_y)
  );

  // Priority mux; held at zero while reset is asserted so the bus reads clean.
  always_comb begin
    wbus = '0;
    if (!clr_n)     wbus = '0;
    else if (EP)    wbus = {{(DW-AW){1'b0}}, pc};
    else if (!CE_n) wbus = ram[mar];
    else if (!EI_n) wbus = {{(DW-AW){1'b0}}, ir[AW-1:0]};
    else if (EA)    wbus = a_reg;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc      <= '0;
      mar     <= '0;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      out_reg <= '0;
      halted  <= 1'b0;
    end else begin
      if (HLT_E) halted <= 1'b1;
      if (!halted) begin
        if (j && !EI_n) pc <= ir[AW-1:0];
        else if (CP)    pc <= pc + AW'(1);
        if (!Lm_n) mar     <= wbus[AW-1:0];
        if (!LI_n) ir      <= wbus;
        if (!LB_n) b_reg   <= wbus;
        if (!LO_n) out_reg <= wbus;
        if (!LA_n) a_reg   <= (Alu_Controller == ALU_PASS) ? wbus : alu_y;
      end
    end
  end

  // Program image is only writable while the machine is halted; contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_we && halted) ram[prog_addr] <= prog_data;
  end

`ifdef BUS_CONTENTION_CHK_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                                       bus_err <= 1'b0;
    else if (!halted && multi_hot4({EP, !CE_n, !EI_n, EA})) bus_err <= 1'b1;
  end
`endif

  assign ins_in   = ir[DW-1:DW-4];
  assign out_port = out_reg;

endmodule
